// File: rtl/alu.sv
// rtl/alu.sv - 4-bit, 16-function ALU with a registered 8-bit result
module alu (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic [3:0] S,
   output logic [7:0] OUT
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_MOD  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_NAND = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b1001;
   localparam logic [3:0] OP_XNOR = 4'b1010;
   localparam logic [3:0] OP_NOT  = 4'b1011;
   localparam logic [3:0] OP_SHL  = 4'b1100;
   localparam logic [3:0] OP_SHR  = 4'b1101;
   localparam logic [3:0] OP_CMP  = 4'b1110;
   localparam logic [3:0] OP_INC  = 4'b1111;

   logic [7:0] a_ext;
   logic [7:0] b_ext;
   logic [3:0] divisor;
   logic [3:0] quot;
   logic [3:0] rem;
   logic [7:0] result;

   assign a_ext = {4'b0000, A};
   assign b_ext = {4'b0000, B};

   // Divider never sees zero; the B==0 cases are overridden in the mux below.
   assign divisor = (B == 4'd0) ? 4'd1 : B;
   assign quot    = A / divisor;
   assign rem     = A % divisor;

   always_comb begin
      result = 8'h00;
      case (S)
         OP_ADD:  result = a_ext + b_ext;
         OP_SUB:  result = a_ext - b_ext;
         OP_MUL:  result = a_ext * b_ext;
         OP_DIV:  result = (B == 4'd0) ? 8'hFF : {4'b0000, quot};
         OP_MOD:  result = (B == 4'd0) ? a_ext : {4'b0000, rem};
         OP_AND:  result = {4'b0000, A & B};
         OP_OR:   result = {4'b0000, A | B};
         OP_XOR:  result = {4'b0000, A ^ B};
         OP_NAND: result = {4'b0000, ~(A & B)};
         OP_NOR:  result = {4'b0000, ~(A | B)};
         OP_XNOR: result = {4'b0000, ~(A ^ B)};
         OP_NOT:  result = {4'b0000, ~A};
         OP_SHL:  result = {3'b000, A, 1'b0};
         OP_SHR:  result = {5'b00000, A[3:1]};
         OP_CMP:  result = {5'b00000, (A > B), (A == B), (A < B)};
         OP_INC:  result = a_ext + 8'd1;
         default: result = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         OUT <= 8'h00;
      end else begin
         OUT <= result;
      end
   end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed scoreboard bench for alu
module tb_alu;

   logic       clk;
   logic       rst_n;
   logic [3:0] A;
   logic [3:0] B;
   logic [3:0] S;
   logic [7:0] OUT;

   int checks;
   int errors;

   logic [7:0] exp_q[$];
   string      tag_q[$];

   alu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .S     (S),
      .OUT   (OUT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_out(input string tag, input logic [7:0] expv);
      checks++;
      assert (OUT === expv)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, OUT, expv);
      end
   endtask

   // Drive one operation at the falling edge, push its expectation, then
   // pop and compare just after the following rising edge.
   task automatic step(input string tag, input logic rst, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] s, input logic [7:0] expv);
      logic [7:0] e;
      string      t;
      @(negedge clk);
      rst_n = rst;
      A     = a;
      B     = b;
      S     = s;
      exp_q.push_back(expv);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check_out(t, e);
      end
   endtask

   initial begin
      logic [7:0] sweep [16];
      logic [7:0] held;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      A      = 4'd0;
      B      = 4'd0;
      S      = 4'd0;

      step("reset0", 1'b0, 4'd3, 4'd5, 4'b0000, 8'h00);
      step("reset1", 1'b0, 4'd3, 4'd5, 4'b0000, 8'h00);
      step("release_add", 1'b1, 4'd3, 4'd5, 4'b0000, 8'h08);

      sweep = '{8'h08, 8'hFE, 8'h0F, 8'h00, 8'h03, 8'h01, 8'h07, 8'h06,
                8'h0E, 8'h08, 8'h09, 8'h0C, 8'h06, 8'h01, 8'h01, 8'h04};
      for (int i = 0; i < 16; i++) begin
         step($sformatf("sweep_op%0d", i), 1'b1, 4'd3, 4'd5, 4'(i), sweep[i]);
      end

      step("max_add", 1'b1, 4'd15, 4'd15, 4'b0000, 8'h1E);
      step("max_mul", 1'b1, 4'd15, 4'd15, 4'b0010, 8'hE1);
      step("max_sub", 1'b1, 4'd15, 4'd15, 4'b0001, 8'h00);
      step("max_cmp", 1'b1, 4'd15, 4'd15, 4'b1110, 8'h02);
      step("max_inc", 1'b1, 4'd15, 4'd15, 4'b1111, 8'h10);
      step("max_shl", 1'b1, 4'd15, 4'd15, 4'b1100, 8'h1E);
      step("max_shr", 1'b1, 4'd15, 4'd15, 4'b1101, 8'h07);
      step("max_not", 1'b1, 4'd15, 4'd15, 4'b1011, 8'h00);

      step("div0", 1'b1, 4'd9, 4'd0, 4'b0011, 8'hFF);
      step("mod0", 1'b1, 4'd9, 4'd0, 4'b0100, 8'h09);
      step("div9_4", 1'b1, 4'd9, 4'd4, 4'b0011, 8'h02);
      step("mod9_4", 1'b1, 4'd9, 4'd4, 4'b0100, 8'h01);

      step("sub0_15", 1'b1, 4'd0, 4'd15, 4'b0001, 8'hF1);
      step("cmp0_15", 1'b1, 4'd0, 4'd15, 4'b1110, 8'h01);
      step("cmp10_2", 1'b1, 4'd10, 4'd2, 4'b1110, 8'h04);

      // Inputs wiggled between edges must not disturb the registered result.
      held = 8'h04;
      #1;
      A = 4'd7;
      B = 4'd1;
      S = 4'b0010;
      #2;
      check_out("midcycle_hold", held);

      step("lat_add", 1'b1, 4'd6, 4'd7, 4'b0000, 8'h0D);
      step("lat_xor", 1'b1, 4'd6, 4'd7, 4'b0111, 8'h01);
      step("lat_mid_rst", 1'b0, 4'd6, 4'd7, 4'b0010, 8'h00);
      step("lat_resume_mul", 1'b1, 4'd6, 4'd7, 4'b0010, 8'h2A);
      step("lat_shl", 1'b1, 4'd9, 4'd7, 4'b1100, 8'h12);
      step("lat_nor", 1'b1, 4'd9, 4'd2, 4'b1001, 8'h04);
      step("lat_and", 1'b1, 4'd12, 4'd10, 4'b0101, 8'h08);

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain observed %0d expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 4-bit, 16-function arithmetic/logic unit with a registered 8-bit result.
- Operands A and B and opcode S are sampled on each rising clock edge; the result appears on OUT after that edge.
- Used as the datapath compute block, driven combinationally by upstream logic and read by downstream logic one cycle later.

Parameters:
- none (widths fixed: operands 4 bits, result 8 bits)

Ports:
- clk    input   1  system clock; all state updates on rising edge
- rst_n  input   1  synchronous, active-low reset
- A      input   4  operand A, unsigned unless the opcode states otherwise
- B      input   4  operand B, unsigned unless the opcode states otherwise
- S      input   4  operation select (opcode)
- OUT    output  8  registered result

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset: on a rising clk edge with rst_n=0, OUT <= 8'h00. Reset has priority over any opcode. rst_n is sampled only at clk edges.
- Normal operation: on each rising edge with rst_n=1, OUT <= f(S, A, B), computed from the values present at that edge.
- Latency: exactly 1 cycle. No handshake; a new operation is accepted every cycle. OUT holds its value between edges.
- Results are 8 bits. Unless stated otherwise, a 4-bit result is zero-extended.
- Opcode map:
  - 0000 ADD: {3'b0, A+B}; bit4 is the carry.
  - 0001 SUB: A-B as 8-bit two's complement (e.g. 3-5 = 8'hFE).
  - 0010 MUL: A*B, full 8-bit unsigned product.
  - 0011 DIV: A/B unsigned quotient, zero-extended. If B=0, OUT=8'hFF.
  - 0100 MOD: A%B unsigned remainder, zero-extended. If B=0, OUT={4'b0,A}.
  - 0101 AND: A&B
  - 0110 OR: A|B
  - 0111 XOR: A^B
  - 1000 NAND: ~(A&B), 4-bit, zero-extended
  - 1001 NOR: ~(A|B), 4-bit, zero-extended
  - 1010 XNOR: ~(A^B), 4-bit, zero-extended
  - 1011 NOT: ~A, 4-bit, zero-extended; B ignored
  - 1100 SHL: {3'b0,A,1'b0}, i.e. A<<1 with no bit loss; B ignored
  - 1101 SHR: {4'b0,1'b0,A[3:1]}, logical; B ignored
  - 1110 CMP: {5'b0, A>B, A==B, A<B}, unsigned; exactly one of bits 2:0 is set
  - 1111 INC: A+1 in 8 bits (A=15 gives 8'h10); B ignored
- Boundary conditions:
  - Max operands (A=B=15): ADD 8'h1E, MUL 8'hE1, SUB 8'h00.
  - Divide by zero never produces X; it follows the DIV/MOD rules above.
  - All 16 opcodes are defined; there is no illegal state and no X on OUT after reset.
  - Inputs changing mid-cycle do not affect OUT until the next edge.

Test Plan:
- Reset: rst_n=0 for 2 edges with A=3, B=5, S=0000 -> OUT=8'h00. Release rst_n; next edge -> OUT=8'h08.
- Opcode sweep: A=3, B=5, S stepped 0000..1111 one per cycle. Each edge gives, in order: 08, FE, 0F, 00, 03, 01, 07, 06, 0E, 08, 09, 0C, 06, 01, 01, 04 (hex).
- Extremes: A=15, B=15 -> ADD 1E, MUL E1, SUB 00, CMP 02, INC 10, SHL 1E.
- Divide by zero: A=9, B=0 -> DIV FF, MOD 09. Then A=9, B=4 -> DIV 02, MOD 01.
- Signed subtract and compare: A=0, B=15 -> SUB F1, CMP 01. A=10, B=2 -> CMP 04.
- Latency and mid-run reset: change S on every cycle and check that OUT reflects the previous edge's inputs. Assert rst_n=0 mid-sequence -> OUT=00 at that edge, and normal results resume on the first edge after release.
